// File: rtl/gmii_mon_pkg.sv
// Shared types, line symbols and CRC-32 helpers for the passive GMII/MII frame monitor.
package gmii_mon_pkg;

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} mon_state_e;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  // Bit-reversed CRC_POLY, used by the LSB-first shift register.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gmii_nibble_pack.sv
// MII nibble-to-byte assembler: low nibble first, strobes a byte on every second nibble.
module gmii_nibble_pack (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       vld_i,
  input  logic [3:0] nib_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       pend_o
);

  logic       pend_q, pend_d;
  logic [3:0] low_q, low_d;

  always_comb begin
    pend_d = pend_q;
    low_d  = low_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end else if (vld_i) begin
      pend_d = ~pend_q;
      if (!pend_q) low_d = nib_i;
    end
  end

  assign byte_vld_o = vld_i & pend_q & ~clr_i;
  assign byte_o     = {nib_i, low_q};
  assign pend_o     = pend_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      low_q  <= 4'h0;
    end else begin
      pend_q <= pend_d;
      low_q  <= low_d;
    end
  end

endmodule

// File: rtl/gmii_frame_monitor.sv
// Passive GMII (DW=8) / MII (DW=4) frame monitor emitting one status record per frame.
// Define MON_STATS_EN to add saturating good/bad frame and good-byte counters.
module gmii_frame_monitor
  import gmii_mon_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_en,
  input  logic             mon_er,
  input  logic             mon_col,
  input  logic [DW-1:0]    mon_data,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_ok,
  output logic             crc_err,
  output logic             runt_err,
  output logic             giant_err,
  output logic             code_err,
  output logic             col_err,
  output logic             pre_err,
  output logic             align_err
`ifdef MON_STATS_EN
  ,
  output logic [LEN_W-1:0] stat_ok,
  output logic [LEN_W-1:0] stat_bad,
  output logic [LEN_W-1:0] stat_bytes
`endif
);

  localparam logic [DW-1:0]    PreSym  = (DW == 4) ? DW'(PRE_NIB) : DW'(PRE_BYTE);
  localparam logic [DW-1:0]    SfdSym  = (DW == 4) ? DW'(SFD_NIB) : DW'(SFD_BYTE);
  localparam logic [LEN_W-1:0] MinLenL = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);

  mon_state_e       state_q, state_d;
  logic             en_q;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             code_q, code_d, col_q, col_d, pre_q, pre_d;

  logic             rec_done_q, rec_done_d, rec_ok_q, rec_ok_d;
  logic [LEN_W-1:0] rec_len_q, rec_len_d;
  logic             rec_crc_q, rec_crc_d, rec_runt_q, rec_runt_d, rec_giant_q, rec_giant_d;
  logic             rec_code_q, rec_code_d, rec_col_q, rec_col_d;
  logic             rec_pre_q, rec_pre_d, rec_align_q, rec_align_d;

  logic             in_vld, byte_vld, half_pend, report;
  logic [7:0]       byte_data;

  assign in_vld = (state_q == StData) && mon_en;

  if (DW == 8) begin : g_byte
    assign byte_vld  = in_vld;
    assign byte_data = mon_data;
    assign half_pend = 1'b0;
  end else if (DW == 4) begin : g_nib
    logic pack_clr;
    assign pack_clr = (state_q != StData);
    gmii_nibble_pack u_pack (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (pack_clr),
      .vld_i      (in_vld),
      .nib_i      (mon_data),
      .byte_vld_o (byte_vld),
      .byte_o     (byte_data),
      .pend_o     (half_pend)
    );
  end else begin : g_bad
    $error("gmii_frame_monitor: DW must be 4 or 8");
    assign byte_vld  = 1'b0;
    assign byte_data = 8'h00;
    assign half_pend = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    code_d      = code_q;
    col_d       = col_q;
    pre_d       = pre_q;
    report      = 1'b0;
    rec_done_d  = 1'b0;
    rec_len_d   = rec_len_q;
    rec_ok_d    = rec_ok_q;
    rec_crc_d   = rec_crc_q;
    rec_runt_d  = rec_runt_q;
    rec_giant_d = rec_giant_q;
    rec_code_d  = rec_code_q;
    rec_col_d   = rec_col_q;
    rec_pre_d   = rec_pre_q;
    rec_align_d = rec_align_q;

    if (state_q != StIdle) begin
      if (mon_en && mon_er) code_d = 1'b1;
      if (mon_col) col_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (mon_en && !en_q) begin
          if (mon_data == PreSym) begin
            state_d = StPreamble;
          end else if (mon_data == SfdSym) begin
            state_d = StData;
          end else begin
            state_d = StDrop;
            pre_d   = 1'b1;
          end
        end
      end
      StPreamble: begin
        if (!mon_en) begin
          report = 1'b1;
          pre_d  = 1'b1;
        end else if (mon_data == SfdSym) begin
          state_d = StData;
        end else if (mon_data != PreSym) begin
          state_d = StDrop;
          pre_d   = 1'b1;
        end
      end
      StData: begin
        if (!mon_en) begin
          report = 1'b1;
        end else if (byte_vld) begin
          crc_d = crc32_byte(crc_q, byte_data);
          if (len_q != '1) len_d = len_q + 1'b1;
        end
      end
      StDrop: begin
        if (!mon_en) report = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (report) begin
      rec_done_d  = 1'b1;
      rec_len_d   = len_q;
      // The reflected register holds the residue in bit-reversed order.
      rec_crc_d   = (state_q == StData) && (bit_rev32(crc_q) != CRC_RESIDUE);
      rec_align_d = (state_q == StData) && half_pend;
      rec_runt_d  = len_q < MinLenL;
      rec_giant_d = len_q > MaxLenL;
      rec_code_d  = code_d;
      rec_col_d   = col_d;
      rec_pre_d   = pre_d;
      rec_ok_d    = !(rec_crc_d || rec_align_d || rec_runt_d || rec_giant_d ||
                      rec_code_d || rec_col_d || rec_pre_d);
      state_d     = StIdle;
      crc_d       = CRC_INIT;
      len_d       = '0;
      code_d      = 1'b0;
      col_d       = 1'b0;
      pre_d       = 1'b0;
    end
  end

  // en_q resets high so a frame already in flight at reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      en_q        <= 1'b1;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      code_q      <= 1'b0;
      col_q       <= 1'b0;
      pre_q       <= 1'b0;
      rec_done_q  <= 1'b0;
      rec_len_q   <= '0;
      rec_ok_q    <= 1'b0;
      rec_crc_q   <= 1'b0;
      rec_runt_q  <= 1'b0;
      rec_giant_q <= 1'b0;
      rec_code_q  <= 1'b0;
      rec_col_q   <= 1'b0;
      rec_pre_q   <= 1'b0;
      rec_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= mon_en;
      crc_q       <= crc_d;
      len_q       <= len_d;
      code_q      <= code_d;
      col_q       <= col_d;
      pre_q       <= pre_d;
      rec_done_q  <= rec_done_d;
      rec_len_q   <= rec_len_d;
      rec_ok_q    <= rec_ok_d;
      rec_crc_q   <= rec_crc_d;
      rec_runt_q  <= rec_runt_d;
      rec_giant_q <= rec_giant_d;
      rec_code_q  <= rec_code_d;
      rec_col_q   <= rec_col_d;
      rec_pre_q   <= rec_pre_d;
      rec_align_q <= rec_align_d;
    end
  end

  assign frame_done = rec_done_q;
  assign frame_len  = rec_len_q;
  assign frame_ok   = rec_ok_q;
  assign crc_err    = rec_crc_q;
  assign runt_err   = rec_runt_q;
  assign giant_err  = rec_giant_q;
  assign code_err   = rec_code_q;
  assign col_err    = rec_col_q;
  assign pre_err    = rec_pre_q;
  assign align_err  = rec_align_q;

`ifdef MON_STATS_EN
  logic [LEN_W-1:0] stat_ok_q, stat_ok_d, stat_bad_q, stat_bad_d, stat_bytes_q, stat_bytes_d;
  logic [LEN_W:0]   bytes_sum;

  always_comb begin
    stat_ok_d    = stat_ok_q;
    stat_bad_d   = stat_bad_q;
    stat_bytes_d = stat_bytes_q;
    bytes_sum    = {1'b0, stat_bytes_q} + {1'b0, rec_len_q};
    if (rec_done_q) begin
      if (rec_ok_q) begin
        if (stat_ok_q != '1) stat_ok_d = stat_ok_q + 1'b1;
        stat_bytes_d = bytes_sum[LEN_W] ? '1 : bytes_sum[LEN_W-1:0];
      end else if (stat_bad_q != '1) begin
        stat_bad_d = stat_bad_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ok_q    <= '0;
      stat_bad_q   <= '0;
      stat_bytes_q <= '0;
    end else begin
      stat_ok_q    <= stat_ok_d;
      stat_bad_q   <= stat_bad_d;
      stat_bytes_q <= stat_bytes_d;
    end
  end

  assign stat_ok    = stat_ok_q;
  assign stat_bad   = stat_bad_q;
  assign stat_bytes = stat_bytes_q;
`endif

endmodule
